// File: rtl/apb_master_if.sv
// Bundle of command, response and APB completer signals for apb_master.
// The master modport is the DUT view; the slave modport is the view of
// whatever drives commands, consumes responses and models the completer.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    // response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    // APB request
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    // APB completer response
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// APB requester: turns one command into a SETUP/ACCESS transfer, waits for
// PREADY up to TIMEOUT access cycles, and returns a held response.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wait count value seen during the last allowed ACCESS cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  cmd_ready_c;

    // Next-state and output computation for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        // A new command may only start once the previous response is gone
        // or is being consumed on this very edge.
        cmd_ready_c = (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_c) begin
                    paddr_d   = bus.cmd_addr;
                    pwrite_d  = bus.cmd_write;
                    pwdata_d  = bus.cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over a timeout landing in the same cycle.
                if (bus.PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, read with waits, slave error,
// timeout and its PREADY-priority case, response backpressure, and reset
// during an ACCESS wait state. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_apb_master;

    logic PCLK;
    logic PRESETn;
    int   checks;
    int   errors;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command for exactly one edge; caller is at a falling edge
    // with the block idle and no pending response.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = data;
        #1;
        check("issue_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'hFFFF_FFFF;
        bus.cmd_wdata = 32'hFFFF_FFFF;
    endtask

    // Pop a held response with a one-cycle rsp_ready pulse.
    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("consume_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_psel", 64'(bus.PSEL), 64'd0);
        check("rst_penable", 64'(bus.PENABLE), 64'd0);
        check("rst_paddr", 64'(bus.PADDR), 64'd0);
        check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
        check("rst_pwrite", 64'(bus.PWRITE), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        PRESETn = 1'b1;
        tick();

        // ---- write, zero wait states ----
        bus.PREADY = 1'b1;
        issue(1'b1, 32'h10, 32'hA5A5_0001);
        check("wr_setup_psel", 64'(bus.PSEL), 64'd1);
        check("wr_setup_penable", 64'(bus.PENABLE), 64'd0);
        check("wr_setup_paddr", 64'(bus.PADDR), 64'h10);
        check("wr_setup_pwrite", 64'(bus.PWRITE), 64'd1);
        check("wr_setup_pwdata", 64'(bus.PWDATA), 64'hA5A5_0001);
        bus.cmd_valid = 1'b1;   // ignored while busy
        #1;
        check("wr_setup_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        bus.cmd_valid = 1'b0;
        check("wr_access_psel", 64'(bus.PSEL), 64'd1);
        check("wr_access_penable", 64'(bus.PENABLE), 64'd1);
        check("wr_access_pwdata", 64'(bus.PWDATA), 64'hA5A5_0001);
        check("wr_access_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        check("wr_done_psel", 64'(bus.PSEL), 64'd0);
        check("wr_done_penable", 64'(bus.PENABLE), 64'd0);
        check("wr_done_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("wr_done_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("wr_done_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("wr_done_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        check("wr_done_paddr_held", 64'(bus.PADDR), 64'h10);
        consume();

        // ---- read, three wait states ----
        bus.PREADY = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        check("rd_setup_pwrite", 64'(bus.PWRITE), 64'd0);
        check("rd_setup_penable", 64'(bus.PENABLE), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_access_penable", 64'(bus.PENABLE), 64'd1);
            check("rd_access_psel", 64'(bus.PSEL), 64'd1);
            check("rd_access_paddr", 64'(bus.PADDR), 64'h10);
            if (i == 3) begin
                bus.PREADY = 1'b1;
                bus.PRDATA = 32'hA5A5_0001;
            end
        end
        tick();
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h0;
        check("rd_done_psel", 64'(bus.PSEL), 64'd0);
        check("rd_done_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rd_done_rsp_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0001);
        check("rd_done_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rd_done_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        consume();

        // ---- slave error on a write ----
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hDEAD_BEEF;
        issue(1'b1, 32'h400, 32'h5555_AAAA);
        tick();
        tick();
        bus.PSLVERR = 1'b0;
        check("err_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("err_rsp_err", 64'(bus.rsp_err), 64'd1);
        check("err_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        check("err_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("err_paddr", 64'(bus.PADDR), 64'h400);
        consume();

        // ---- timeout: PREADY never arrives ----
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'h1234_5678;
        issue(1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_access_penable", 64'(bus.PENABLE), 64'd1);
            check("to_access_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end
        tick();
        check("to_done_psel", 64'(bus.PSEL), 64'd0);
        check("to_done_penable", 64'(bus.PENABLE), 64'd0);
        check("to_done_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("to_done_rsp_err", 64'(bus.rsp_err), 64'd1);
        check("to_done_rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
        check("to_done_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        consume();

        // ---- PREADY in the 4th ACCESS cycle beats the timeout ----
        bus.PRDATA = 32'h0F0F_1234;
        issue(1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tp_access_penable", 64'(bus.PENABLE), 64'd1);
            if (i == 3) bus.PREADY = 1'b1;
        end
        tick();
        bus.PREADY = 1'b0;
        check("tp_done_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("tp_done_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("tp_done_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        check("tp_done_rsp_rdata", 64'(bus.rsp_rdata), 64'h0F0F_1234);
        consume();

        // ---- response backpressure with a queued command ----
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h0BAD_F00D;
        issue(1'b0, 32'h28, 32'h0);
        tick();
        tick();
        bus.PRDATA    = 32'h0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h30;
        bus.cmd_wdata = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'h0BAD_F00D);
            check("bp_rsp_err", 64'(bus.rsp_err), 64'd0);
            check("bp_psel", 64'(bus.PSEL), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("bp_next_psel", 64'(bus.PSEL), 64'd1);
        check("bp_next_penable", 64'(bus.PENABLE), 64'd0);
        check("bp_next_paddr", 64'(bus.PADDR), 64'h30);
        check("bp_next_pwdata", 64'(bus.PWDATA), 64'h1111_2222);
        check("bp_next_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        tick();
        check("bp_next_done_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_next_done_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        consume();

        // ---- reset during an ACCESS wait state ----
        bus.PREADY = 1'b0;
        issue(1'b0, 32'h40, 32'h0);
        tick();
        check("rs_access_penable", 64'(bus.PENABLE), 64'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rs_async_psel", 64'(bus.PSEL), 64'd0);
        check("rs_async_penable", 64'(bus.PENABLE), 64'd0);
        tick();
        PRESETn = 1'b1;
        bus.PREADY = 1'b1;
        #1;
        check("rs_after_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rs_after_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rs_after_paddr", 64'(bus.PADDR), 64'd0);
        tick();
        check("rs_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        issue(1'b1, 32'h44, 32'hCAFE_F00D);
        check("rs_next_psel", 64'(bus.PSEL), 64'd1);
        tick();
        check("rs_next_penable", 64'(bus.PENABLE), 64'd1);
        tick();
        check("rs_next_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rs_next_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rs_next_pwdata", 64'(bus.PWDATA), 64'hCAFE_F00D);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles waited for PREADY (legal range 1..255).
REQ-004 PCLK  input  1  single clock; all state on rising edge.
REQ-005 PRESETn  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-014 rsp_err  output  1  PSLVERR seen, or timeout.
REQ-015 rsp_timeout  output  1  transfer aborted by timeout.
REQ-016 PADDR  output  ADDR_WIDTH; PSEL  output  1; PENABLE  output  1; PWRITE  output  1; PWDATA  output  DATA_WIDTH  APB request signals, all registered.
REQ-017 PREADY  input  1; PRDATA  input  DATA_WIDTH; PSLVERR  input  1  APB completer response.

Function
REQ-018 SHALL implement states IDLE, SETUP, ACCESS; encoding free.
REQ-019 cmd_ready SHALL equal (state==IDLE) && (!rsp_valid || rsp_ready), combinationally.
REQ-020 On a cmd_valid && cmd_ready edge: SHALL register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0, go to SETUP.
REQ-021 SETUP SHALL last exactly one cycle, then go to ACCESS with PSEL=1, PENABLE=1.
REQ-022 PADDR, PWRITE, PWDATA SHALL stay stable from SETUP through the final ACCESS cycle, and hold their last value in IDLE.
REQ-023 In ACCESS, PREADY SHALL be sampled each rising edge; on PREADY=1: rsp_valid<=1, rsp_err<=PSLVERR, rsp_timeout<=0, rsp_rdata<=PRDATA if read else 0; PSEL<=0, PENABLE<=0; go to IDLE.
REQ-024 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-025 If PREADY=0 on the edge where the counter reaches TIMEOUT-1 (the TIMEOUT-th ACCESS cycle), SHALL abort: rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0, PSEL<=0, PENABLE<=0, go to IDLE.
REQ-026 PREADY=1 in the timeout cycle SHALL take priority over the timeout (normal completion).
REQ-027 Zero-wait latency: command accepted at edge N -> PSEL high after N, PENABLE high after N+1, rsp_valid high after N+2.
REQ-028 rsp_valid, rsp_rdata, rsp_err, rsp_timeout SHALL hold until the edge with rsp_ready=1, then rsp_valid<=0 unless a new response is loaded on that edge.
REQ-029 A new command SHALL be accepted in IDLE on the same edge the held response is consumed; minimum spacing between command acceptances is 3 cycles.
REQ-030 cmd_valid while not in IDLE SHALL be ignored (cmd_ready=0); inputs need not stay stable.
REQ-031 PSEL=1 SHALL only occur in SETUP/ACCESS; PENABLE=1 only in ACCESS.

Reset
REQ-032 PRESETn=0 SHALL immediately force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0.
REQ-033 Reset asserted mid-transfer (SETUP or ACCESS) SHALL abandon the transfer with no response; after release the block SHALL be in IDLE with cmd_ready=1.

Verification
REQ-034 Write: cmd addr=0x10, wdata=0xA5A5_0001, PREADY=1 in first ACCESS cycle -> PSEL 2 cycles, PENABLE 1 cycle, PWDATA stable; rsp_valid, rsp_err=0, rsp_rdata=0.
REQ-035 Read: addr=0x10, completer returns PRDATA=0xA5A5_0001 with 3 wait states -> ACCESS lasts 4 cycles, rsp_rdata=0xA5A5_0001, rsp_err=0.
REQ-036 Error: addr=0x400, PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-037 Timeout: TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSEL=0 and rsp_err=1, rsp_timeout=1; repeat with PREADY=1 in 4th cycle -> normal completion.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles after a response -> response fields held, cmd_ready=0 throughout; cmd_ready=1 on the rsp_ready=1 cycle and a queued command is accepted on that edge.
REQ-039 Reset in ACCESS: PRESETn low for 1 cycle during wait state -> PSEL/PENABLE drop asynchronously, no rsp_valid; next command completes normally.
